sram_read_arbiter: RTL
======================

# sram_read_arbiter

Two-port, read-only arbiter for the board SRAM. It shares the single SRAM address/data path between two instruction fetchers, for example the melody voice and the accompaniment voice. Each fetcher issues one read request at a time. The block grants requests round-robin, drives `SRAM_A`, waits the fixed SRAM access latency, then returns the captured word with a one-cycle valid pulse to the owner.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: clock edges from driving `SRAM_A` to sampling `SRAM_D`. Legal range is 1..15; 0 is illegal.

Ports:
- `CLK` in 1: 50 MHz clock. One clock; reset is synchronous and active-high.
- `RST` in 1: synchronous, active-high reset.
- `req0` in 1: read request, port 0. Hold it high until `gnt0`.
- `addr0` in 18: read address, port 0. Must be stable while `req0` is high.
- `gnt0` out 1: one-cycle pulse; port 0's request has been accepted.
- `rvalid0` out 1: one-cycle pulse; `rdata` holds port 0's word.
- `req1` / `addr1` / `gnt1` / `rvalid1`: same as the port 0 signals, for port 1.
- `rdata` out 16: last captured SRAM word, shared by both ports.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `SRAM_A` out 18: SRAM address, registered.
- `SRAM_D` in 16: SRAM data.
- `SRAM_WE`, `SRAM_CE`, `SRAM_OE`, `SRAM_LB`, `SRAM_UB` out 1 each: tied to 1, 0, 0, 0, 0 (read-only, both bytes).

## Operation
FSM states:
- IDLE:
  - If any request is present at an edge, pick a winner and latch its address into `SRAM_A`.
  - Register `gnt<w>`=1 and record the owner.
  - Load the wait counter with `WAIT_CYCLES`, then go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 1, capture `SRAM_D` into `rdata` and set `rvalid<owner>`=1.
  - Return to IDLE on that same edge.

Arbitration rules:
- A single requester wins outright.
- When both ports request, the port that did not own the previous grant wins.
- The last-owner pointer resets to 1, so port 0 wins the first tie.
- The pointer updates only on a grant.

Handshake rules:
- Each `gnt` consumes exactly one request.
- A requester that keeps `req` high after `gnt` is treated as issuing a new request at the next IDLE edge. This is legal and gives streaming reads.
- Changing `addr` while `req` is high and `gnt` has not been seen is illegal and undefined.
- Requests are ignored in WAIT; they are not queued.

Output behaviour:
- `SRAM_A` holds its value after capture, until the next grant.
- `rdata` holds until the next capture.
- Widths: the counter is 4 bits, and addresses pass through unmodified.

## Timing
- Grant at edge E0:
  - `gnt` is high during the cycle after E0.
  - `SRAM_A` is valid from E0.
  - `SRAM_D` is sampled at edge E0+`WAIT_CYCLES`.
  - `rvalid` and `rdata` are valid in the cycle after that edge.
- Next arbitration happens at edge E0+`WAIT_CYCLES`+1. Peak throughput is one read per `WAIT_CYCLES`+1 cycles; with the default, one read every 3 cycles.
- `gnt` and `rvalid` are never high in the same cycle. With `WAIT_CYCLES`=1 they are on adjacent cycles.
- Reset values: `gnt*`=0, `rvalid*`=0, `rdata`=0, `SRAM_A`=0, `busy`=0, state IDLE, pointer=1.
- Reset asserted mid-WAIT aborts the read: no `rvalid` is produced, and the requester must re-request.
- Reset wins over any simultaneous request.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins ties, and the pointer logic is removed. Port 1 can starve while `req0` is held.
- Undefined (default): round-robin as described in Operation.

## Structure
- `sram_arb_pkg` holds:
  - the state enum (IDLE, WAIT);
  - `SRAM_ADDR_W`=18 and `SRAM_DATA_W`=16;
  - the constant SRAM control levels.
- The natural sub-module is `rr_pick2`: a combinational 2-way picker that takes req0, req1 and last-owner and outputs the winner and a valid flag. It contains the `SRAM_ARB_FIXED_PRIO_EN` switch.

## Test plan
- Single read: `req0`=1, `addr0`=0x00005, SRAM model returns 0x8A3C → `gnt0` 1 cycle later; `SRAM_A`=0x00005; `rvalid0` with `rdata`=0x8A3C exactly 2 cycles after `gnt0`. `rvalid1` and `gnt1` stay 0.
- Tie, round-robin: both request from reset, `addr0`=0x10, `addr1`=0x20, both held high → grants alternate 0,1,0,1 every 3 cycles; `SRAM_A` sequence is 0x10, 0x20, 0x10, 0x20.
- Streaming: `req1` held high, address incremented on each `gnt1` from 0x100 → `rvalid1` every 3 cycles with words at 0x100, 0x101, 0x102.
- Reset mid-read: `RST` pulsed one cycle after `gnt0` → no `rvalid0`; all outputs return to 0; the next `req1` is granted immediately.
- `WAIT_CYCLES`=4: single read → `rvalid` arrives 4 cycles after `gnt`; a second request raised during WAIT is not granted until the FSM returns to IDLE.
- `SRAM_ARB_FIXED_PRIO_EN` defined, both requesting continuously → only `gnt0` pulses; `gnt1` only after `req0` drops.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the board SRAM read arbiter.
// Holds the arbiter state encoding, the SRAM bus widths and the fixed
// control-pin levels used for read-only, full-word access.
package sram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arbState_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WAIT_CNT_W  = 4;

  // Read-only access with both byte lanes enabled (all strobes active-low)
  localparam logic SRAM_WE_LVL = 1'b1;
  localparam logic SRAM_CE_LVL = 1'b0;
  localparam logic SRAM_OE_LVL = 1'b0;
  localparam logic SRAM_LB_LVL = 1'b0;
  localparam logic SRAM_UB_LVL = 1'b0;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way request picker.
// Default build is round-robin: on a tie the port that did not own the
// previous grant wins. Defining SRAM_ARB_FIXED_PRIO_EN makes port 0 always
// win ties and removes the last-owner input altogether.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
`ifndef SRAM_ARB_FIXED_PRIO_EN
  input  logic i_lastOwner,
`endif
  output logic o_winner,
  output logic o_valid
);

  // Pick a winner among the active requesters; a lone requester always wins
  always_comb begin
    o_valid = i_req0 | i_req1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    o_winner = ~i_req0;
`else
    if (i_req0 && i_req1) begin
      o_winner = ~i_lastOwner;
    end else begin
      o_winner = i_req1;
    end
`endif
  end

endmodule

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: shares the single board SRAM read path between two
// fetch ports. A granted request drives SRAM_A, waits WAIT_CYCLES edges,
// then captures SRAM_D into rdata with a one-cycle rvalid to the owner.
// Optional macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module sram_read_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req0,
  input  logic [SRAM_ADDR_W-1:0] addr0,
  output logic                   gnt0,
  output logic                   rvalid0,
  input  logic                   req1,
  input  logic [SRAM_ADDR_W-1:0] addr1,
  output logic                   gnt1,
  output logic                   rvalid1,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   busy,
  output logic [SRAM_ADDR_W-1:0] SRAM_A,
  input  logic [SRAM_DATA_W-1:0] SRAM_D,
  output logic                   SRAM_WE,
  output logic                   SRAM_CE,
  output logic                   SRAM_OE,
  output logic                   SRAM_LB,
  output logic                   SRAM_UB
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  arbState_t             r_state;
  logic [WAIT_CNT_W-1:0] r_count;
  logic                  r_owner;
  logic                  w_winner;
  logic                  w_pickValid;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic                  r_lastOwner;
`endif

  assign busy    = (r_state != IDLE);
  assign SRAM_WE = SRAM_WE_LVL;
  assign SRAM_CE = SRAM_CE_LVL;
  assign SRAM_OE = SRAM_OE_LVL;
  assign SRAM_LB = SRAM_LB_LVL;
  assign SRAM_UB = SRAM_UB_LVL;

  rr_pick2 u_pick (
    .i_req0      (req0),
    .i_req1      (req1),
`ifndef SRAM_ARB_FIXED_PRIO_EN
    .i_lastOwner (r_lastOwner),
`endif
    .o_winner    (w_winner),
    .o_valid     (w_pickValid)
  );

`ifndef SRAM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: remembers the owner of the most recent grant only
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lastOwner <= 1'b1;
    end else if (r_state == IDLE && w_pickValid) begin
      r_lastOwner <= w_winner;
    end
  end
`endif

  // Grant/wait/capture FSM; gnt and rvalid are single-cycle registered pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_count <= '0;
      r_owner <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
      SRAM_A  <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pickValid) begin
            r_owner <= w_winner;
            r_count <= WAIT_LOAD;
            r_state <= WAIT;
            if (w_winner) begin
              SRAM_A <= addr1;
              gnt1   <= 1'b1;
            end else begin
              SRAM_A <= addr0;
              gnt0   <= 1'b1;
            end
          end
        end
        WAIT: begin
          r_count <= r_count - 1'b1;
          if (r_count == WAIT_CNT_W'(1)) begin
            rdata   <= SRAM_D;
            r_state <= IDLE;
            if (r_owner) begin
              rvalid1 <= 1'b1;
            end else begin
              rvalid0 <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
